// File: rtl/nocif_eg_pkg.sv
// rtl/nocif_eg_pkg.sv - shared constants and helpers for the NOCIF write-response egress
package nocif_eg_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'd0;
   localparam logic [1:0] BRESP_EXOKAY = 2'd1;
   localparam logic [1:0] BRESP_SLVERR = 2'd2;
   localparam logic [1:0] BRESP_DECERR = 2'd3;

   // context entry layout: {len, require_ack}
   localparam int REQ_ACK_BIT = 0;
   localparam int LEN_LSB     = 1;

   function automatic int cid_width(input int num_clients);
      return (num_clients > 1) ? $clog2(num_clients) : 1;
   endfunction

endpackage

// File: rtl/nocif_wr_eg_rsp_if.sv
// rtl/nocif_wr_eg_rsp_if.sv - AXI B-channel bundle from the NoC into the write egress
interface nocif_wr_eg_rsp_if #(
   parameter int ID_W = 8
);
   logic            noc2eg_axi_b_bvalid;
   logic            noc2eg_axi_b_bready;
   logic [ID_W-1:0] noc2eg_axi_b_bid;
   logic [1:0]      noc2eg_axi_b_bresp;

   modport master (
      output noc2eg_axi_b_bvalid,
      output noc2eg_axi_b_bid,
      output noc2eg_axi_b_bresp,
      input  noc2eg_axi_b_bready
   );

   modport slave (
      input  noc2eg_axi_b_bvalid,
      input  noc2eg_axi_b_bid,
      input  noc2eg_axi_b_bresp,
      output noc2eg_axi_b_bready
   );
endinterface

// File: rtl/nocif_eg_skid.sv
// rtl/nocif_eg_skid.sv - generic 2-entry FIFO exposing full, empty and head data
module nocif_eg_skid #(
   parameter int DW = 10
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rst,
   input  logic          wr_vld,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);
   logic [DW-1:0] mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic          push;
   logic          pop;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign head  = mem[rd_ptr];
   assign push  = wr_vld && !full;
   assign pop   = rd_pop && !empty;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // storage needs no reset; count alone defines which entries are live
   always_ff @(posedge nvdla_core_clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/nocif_wr_eg_rsp.sv
// rtl/nocif_wr_eg_rsp.sv - matches NoC B responses to per-client context queues
// and reports completion, errors and retired burst lengths.
module nocif_wr_eg_rsp
   import nocif_eg_pkg::*;
#(
   parameter int NUM_CLIENTS = 5,
   parameter int ID_W        = 8,
   parameter int LEN_W       = 2
) (
   input  logic                           nvdla_core_clk,
   input  logic                           nvdla_core_rst,
   nocif_wr_eg_rsp_if.slave               noc2eg_axi_b,
   input  logic [NUM_CLIENTS-1:0]         cq_rd_pvld,
   output logic [NUM_CLIENTS-1:0]         cq_rd_prdy,
   input  logic [NUM_CLIENTS*(LEN_W+1)-1:0] cq_rd_pd,
   output logic [NUM_CLIENTS-1:0]         wr_rsp_complete,
   output logic [NUM_CLIENTS-1:0]         wr_rsp_err,
   input  logic                           err_clr,
   output logic                           bad_id_err,
   output logic [ID_W-1:0]                bad_id_cap,
   output logic                           eg2ig_axi_vld,
   output logic [LEN_W-1:0]               eg2ig_axi_len
);
   localparam int CID_W = cid_width(NUM_CLIENTS);

   logic                   skid_full;
   logic                   skid_empty;
   logic [ID_W+1:0]        skid_head;
   logic [ID_W-1:0]        head_bid;
   logic [1:0]             head_resp;
   logic [CID_W-1:0]       cid;
   logic [NUM_CLIENTS-1:0] sel;
   logic                   ctx_vld;
   logic                   ctx_ack;
   logic [LEN_W-1:0]       ctx_len;
   logic                   valid_id;
   logic                   pop_ok;
   logic                   pop_bad;
   logic                   resp_err;

   assign noc2eg_axi_b.noc2eg_axi_b_bready = !skid_full && !nvdla_core_rst;

   nocif_eg_skid #(.DW(ID_W + 2)) u_skid (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rst (nvdla_core_rst),
      .wr_vld         (noc2eg_axi_b.noc2eg_axi_b_bvalid && noc2eg_axi_b.noc2eg_axi_b_bready),
      .wr_data        ({noc2eg_axi_b.noc2eg_axi_b_bid, noc2eg_axi_b.noc2eg_axi_b_bresp}),
      .rd_pop         (pop_ok || pop_bad),
      .full           (skid_full),
      .empty          (skid_empty),
      .head           (skid_head)
   );

   assign head_bid  = skid_head[ID_W+1:2];
   assign head_resp = skid_head[1:0];
   assign cid       = head_bid[CID_W-1:0];

   // one-hot client select; an all-zero select means the index is out of range
   always_comb begin
      sel     = '0;
      ctx_vld = 1'b0;
      ctx_ack = 1'b0;
      ctx_len = '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
         if (cid == CID_W'(c)) begin
            sel[c]  = 1'b1;
            ctx_vld = cq_rd_pvld[c];
            ctx_ack = cq_rd_pd[c*(LEN_W+1) + REQ_ACK_BIT];
            ctx_len = cq_rd_pd[c*(LEN_W+1) + LEN_LSB +: LEN_W];
         end
      end
   end

   assign valid_id   = |sel;
   assign pop_ok     = !skid_empty && !nvdla_core_rst && valid_id && ctx_vld;
   assign pop_bad    = !skid_empty && !nvdla_core_rst && !valid_id;
   assign resp_err   = (head_resp == BRESP_SLVERR) || (head_resp == BRESP_DECERR);
   assign cq_rd_prdy = sel & {NUM_CLIENTS{pop_ok}};

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         wr_rsp_complete <= '0;
         wr_rsp_err      <= '0;
         bad_id_err      <= 1'b0;
         bad_id_cap      <= '0;
         eg2ig_axi_vld   <= 1'b0;
         eg2ig_axi_len   <= '0;
      end else begin
         wr_rsp_complete <= sel & {NUM_CLIENTS{pop_ok && ctx_ack}};
         eg2ig_axi_vld   <= pop_ok;
         eg2ig_axi_len   <= pop_ok ? ctx_len : '0;
         // a set in the same cycle as err_clr survives the clear
         wr_rsp_err      <= (wr_rsp_err & ~{NUM_CLIENTS{err_clr}})
                          | (sel & {NUM_CLIENTS{pop_ok && resp_err}});
         bad_id_err      <= (bad_id_err && !err_clr) || pop_bad;
         if (pop_bad && (!bad_id_err || err_clr)) begin
            bad_id_cap <= head_bid;
         end else if (err_clr) begin
            bad_id_cap <= '0;
         end
      end
   end
endmodule

// File: tb/tb_nocif_wr_eg_rsp.sv
// tb/tb_nocif_wr_eg_rsp.sv - randomized self-checking bench for nocif_wr_eg_rsp
module tb_nocif_wr_eg_rsp;
   localparam int N   = 5;
   localparam int IDW = 8;
   localparam int LW  = 2;
   localparam int CW  = $clog2(N);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   pvld, prdy, cmp, err;
   logic [N*3-1:0] pd;
   logic           err_clr, bad_err, eg_vld;
   logic [IDW-1:0] cap;
   logic [LW-1:0]  eg_len;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int             qb[$];
   int             qr[$];
   logic [N-1:0]   m_cmp = '0, m_err = '0;
   logic           m_vld = 1'b0, m_bad = 1'b0;
   logic [1:0]     m_len = '0;
   logic [IDW-1:0] m_cap = '0;

   always #5 clk = ~clk;

   nocif_wr_eg_rsp_if #(.ID_W(IDW)) bif ();

   nocif_wr_eg_rsp #(.NUM_CLIENTS(N), .ID_W(IDW), .LEN_W(LW)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rst  (rst),
      .noc2eg_axi_b    (bif.slave),
      .cq_rd_pvld      (pvld),
      .cq_rd_prdy      (prdy),
      .cq_rd_pd        (pd),
      .wr_rsp_complete (cmp),
      .wr_rsp_err      (err),
      .err_clr         (err_clr),
      .bad_id_err      (bad_err),
      .bad_id_cap      (cap),
      .eg2ig_axi_vld   (eg_vld),
      .eg2ig_axi_len   (eg_len)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_prdy();
      logic [N-1:0] r;
      int c;
      r = '0;
      if (!rst && qb.size() > 0) begin
         c = qb[0] % (1 << CW);
         if (c < N && pvld[c]) r[c] = 1'b1;
      end
      return r;
   endfunction

   // compare at the falling edge, then advance the model with the inputs
   // that the next rising edge will sample
   initial forever begin
      int       c;
      logic     acc, old_bad;
      int       ent;
      @(negedge clk);
      chk("bready", 32'(bif.noc2eg_axi_b_bready), 32'(!rst && qb.size() < 2));
      chk("prdy", 32'(prdy), 32'(exp_prdy()));
      chk("prdy_onehot", 32'($onehot0(prdy)), 32'd1);
      chk("complete", 32'(cmp), 32'(m_cmp));
      chk("err", 32'(err), 32'(m_err));
      chk("eg_vld", 32'(eg_vld), 32'(m_vld));
      chk("eg_len", 32'(eg_len), 32'(m_len));
      chk("bad_id_err", 32'(bad_err), 32'(m_bad));
      chk("bad_id_cap", 32'(cap), 32'(m_cap));

      acc = !rst && bif.noc2eg_axi_b_bvalid && qb.size() < 2;
      if (rst) begin
         qb.delete(); qr.delete();
         m_cmp = '0; m_err = '0; m_vld = 0; m_len = 0; m_bad = 0; m_cap = 0;
      end else begin
         old_bad = m_bad;
         m_cmp = '0; m_vld = 0; m_len = 0;
         if (err_clr) begin m_err = '0; m_bad = 0; m_cap = 0; end
         if (qb.size() > 0) begin
            c = qb[0] % (1 << CW);
            if (c >= N) begin
               m_bad = 1;
               if (!old_bad || err_clr) m_cap = IDW'(qb[0]);
               void'(qb.pop_front()); void'(qr.pop_front());
            end else if (pvld[c]) begin
               ent = int'((pd >> (3 * c)) & 15'd7);
               if (ent % 2 == 1) m_cmp[c] = 1'b1;
               m_vld = 1;
               m_len = 2'(ent / 2);
               if (qr[0] >= 2) m_err[c] = 1'b1;
               void'(qb.pop_front()); void'(qr.pop_front());
            end
         end
         if (acc) begin
            qb.push_back(int'(bif.noc2eg_axi_b_bid));
            qr.push_back(int'(bif.noc2eg_axi_b_bresp));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] id, input logic [1:0] rs);
      logic got;
      bif.noc2eg_axi_b_bvalid = 1'b1;
      bif.noc2eg_axi_b_bid    = id;
      bif.noc2eg_axi_b_bresp  = rs;
      for (int k = 0; k < 50; k++) begin
         #3;
         got = bif.noc2eg_axi_b_bready;
         step();
         if (got) begin
            bif.noc2eg_axi_b_bvalid = 1'b0;
            return;
         end
      end
      bif.noc2eg_axi_b_bvalid = 1'b0;
      chk("send_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int cnt;
      bif.noc2eg_axi_b_bvalid = 1'b0;
      bif.noc2eg_axi_b_bid    = '0;
      bif.noc2eg_axi_b_bresp  = '0;
      pvld = '0; pd = '0; err_clr = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // single response, literal latency/values
      pvld = 5'b00010;
      pd[5:3] = 3'b101;
      send(8'h01, 2'd0);
      #3 chk("t1_prdy", 32'(prdy), 32'h02);
      step();
      #3;
      chk("t1_complete", 32'(cmp), 32'h02);
      chk("t1_eg_vld", 32'(eg_vld), 32'd1);
      chk("t1_eg_len", 32'(eg_len), 32'd2);
      step();

      // context stall with back-pressure
      pvld = '0;
      send(8'h00, 2'd0);
      send(8'h20, 2'd0);
      bif.noc2eg_axi_b_bvalid = 1'b1;
      bif.noc2eg_axi_b_bid    = 8'h40;
      for (int k = 0; k < 3; k++) begin
         #3 chk("t2_bready_low", 32'(bif.noc2eg_axi_b_bready), 32'd0);
         step();
      end
      pvld[0] = 1'b1;
      pd[2:0] = 3'b011;
      send(8'h40, 2'd0);
      repeat (3) step();

      // error response, sticky flag and clear priority
      pvld = '1;
      pd[11:9] = 3'b010;
      send(8'h03, 2'd2);
      step();
      #3;
      chk("t3_err", 32'(err), 32'h08);
      chk("t3_complete", 32'(cmp), 32'h00);
      chk("t3_eg_vld", 32'(eg_vld), 32'd1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #3 chk("t3_cleared", 32'(err), 32'h00);
      step();
      send(8'h03, 2'd3);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #3 chk("t3_set_wins", 32'(err), 32'h08);
      step();

      // bad IDs
      send(8'h07, 2'd0);
      step();
      #3;
      chk("t4_bad", 32'(bad_err), 32'd1);
      chk("t4_cap", 32'(cap), 32'h07);
      chk("t4_no_eg", 32'(eg_vld), 32'd0);
      step();
      send(8'h06, 2'd0);
      step();
      #3 chk("t4_cap_kept", 32'(cap), 32'h07);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      repeat (2) step();

      // streaming, round-robin
      cnt = 0;
      pvld = '1;
      for (int i = 0; i < 22; i++) begin
         pd = 15'($urandom);
         if (i < 20) begin
            bif.noc2eg_axi_b_bvalid = 1'b1;
            bif.noc2eg_axi_b_bid    = 8'(i % N);
            bif.noc2eg_axi_b_bresp  = 2'($urandom_range(0, 1));
         end else begin
            bif.noc2eg_axi_b_bvalid = 1'b0;
         end
         #3;
         if (i < 20) chk("t5_bready", 32'(bif.noc2eg_axi_b_bready), 32'd1);
         if (eg_vld) cnt++;
         step();
      end
      #3 if (eg_vld) cnt++;
      chk("t5_pulses", 32'(cnt), 32'd20);
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bif.noc2eg_axi_b_bvalid = ($urandom_range(0, 9) < 7);
         bif.noc2eg_axi_b_bid    = 8'($urandom);
         bif.noc2eg_axi_b_bresp  = 2'($urandom);
         pvld    = 5'($urandom);
         pd      = 15'($urandom);
         err_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      bif.noc2eg_axi_b_bvalid = 1'b0;
      err_clr = 1'b0;
      pvld = '1;
      repeat (4) step();

      // reset with the buffer full
      pvld = '0;
      send(8'h00, 2'd0);
      send(8'h01, 2'd0);
      rst = 1'b1;
      #3 chk("t6_bready_rst", 32'(bif.noc2eg_axi_b_bready), 32'd0);
      step();
      #3 chk("t6_bready_rst2", 32'(bif.noc2eg_axi_b_bready), 32'd0);
      step();
      rst = 1'b0;
      pvld = '1;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         #3 if (eg_vld || (cmp != '0)) cnt++;
         step();
      end
      chk("t6_no_pulses", 32'(cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
